// File: rtl/sdram_arbiter.sv
// Arbitrates one write port and four read ports onto a single SDRAM controller port.
// Define SDRAM_ARB_ROUND_ROBIN_EN for round-robin read grants; default is fixed priority.
module sdram_arbiter #(
  parameter int unsigned ADDR_WIDTH  = 23,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MAX_PENDING = 2
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_req,
  output logic                    wr_ack,
  input  logic [4*ADDR_WIDTH-1:0] rd_addr,
  input  logic [3:0]              rd_req,
  output logic [3:0]              rd_ack,
  output logic [3:0]              rd_valid,
  output logic [4*DATA_WIDTH-1:0] rd_data,
  output logic                    err,
  output logic [ADDR_WIDTH-1:0]   sdram_addr,
  output logic [DATA_WIDTH-1:0]   sdram_data,
  output logic                    sdram_we,
  output logic                    sdram_req,
  input  logic                    sdram_ack,
  input  logic                    sdram_valid,
  input  logic [DATA_WIDTH-1:0]   sdram_q
);

  typedef enum logic {StIdle, StBusy} state_e;

  localparam logic [2:0] MaxPend = 3'(MAX_PENDING);

  state_e                  state_q, state_d;
  logic [1:0]              owner_q, owner_d;
  logic                    req_q, req_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;

  // Tag FIFO: owner of each accepted read, in controller return order.
  logic [1:0]              tag_mem_q [4];
  logic [1:0]              head_q, tail_q;
  logic [2:0]              count_q;

  logic [3:0]              rd_valid_q;
  logic [4*DATA_WIDTH-1:0] rd_data_q;
  logic                    err_q;

  logic                    rd_any;
  logic [1:0]              rd_sel;
  logic                    pending_ok;
  logic                    rd_grant;
  logic                    accept;
  logic                    push;
  logic                    pop;
  logic [1:0]              head_tag;

  assign pending_ok = count_q < MaxPend;
  assign rd_grant   = (state_q == StIdle) && !wr_req && rd_any && pending_ok;
  assign accept     = (state_q == StBusy) && sdram_ack;
  assign push       = accept && !we_q;
  assign pop        = sdram_valid && (count_q != 3'd0);
  assign head_tag   = tag_mem_q[head_q];

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  logic [1:0] rr_q;

  // Walk from rr_q+4 down to rr_q+1 so that rr_q+1 ends up winning.
  always_comb begin
    logic [1:0] idx;
    rd_any = 1'b0;
    rd_sel = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = rr_q + 2'(i);
      if (rd_req[idx]) begin
        rd_any = 1'b1;
        rd_sel = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_q <= 2'd3;
    end else if (rd_grant) begin
      rr_q <= rd_sel;
    end
  end
`else
  always_comb begin
    rd_any = 1'b0;
    rd_sel = '0;
    for (int i = 3; i >= 0; i--) begin
      if (rd_req[i]) begin
        rd_any = 1'b1;
        rd_sel = 2'(i);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (wr_req) begin
          we_d    = 1'b1;
          addr_d  = wr_addr;
          data_d  = wr_data;
          req_d   = 1'b1;
          state_d = StBusy;
        end else if (rd_grant) begin
          owner_d = rd_sel;
          we_d    = 1'b0;
          addr_d  = rd_addr[int'(rd_sel)*ADDR_WIDTH +: ADDR_WIDTH];
          data_d  = '0;
          req_d   = 1'b1;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (sdram_ack) begin
          req_d   = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_ack = '0;
    if (push) rd_ack[owner_q] = 1'b1;
  end

  assign wr_ack = accept && we_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      owner_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) tag_mem_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        tag_mem_q[tail_q] <= owner_q;
        tail_q            <= tail_q + 2'd1;
      end
      if (pop) head_q <= head_q + 2'd1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: ;
      endcase
    end
  end

  // A return with nothing outstanding is dropped and flagged until reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      rd_valid_q <= '0;
      if (pop) begin
        rd_valid_q[head_tag]                                <= 1'b1;
        rd_data_q[int'(head_tag)*DATA_WIDTH +: DATA_WIDTH] <= sdram_q;
      end else if (sdram_valid) begin
        err_q <= 1'b1;
      end
    end
  end

  assign sdram_req  = req_q;
  assign sdram_we   = we_q;
  assign sdram_addr = addr_q;
  assign sdram_data = data_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign err        = err_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: cycle table for a single read and stray return,
// plus sequences for priority, pending limit, coincident ack/valid and async reset.
module tb_sdram_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [22:0]  wr_addr;
  logic [31:0]  wr_data;
  logic         wr_req;
  logic         wr_ack;
  logic [91:0]  rd_addr;
  logic [3:0]   rd_req;
  logic [3:0]   rd_ack;
  logic [3:0]   rd_valid;
  logic [127:0] rd_data;
  logic         err;
  logic [22:0]  sdram_addr;
  logic [31:0]  sdram_data;
  logic         sdram_we;
  logic         sdram_req;
  logic         sdram_ack;
  logic         sdram_valid;
  logic [31:0]  sdram_q;

  int total = 0;
  int bad   = 0;

  sdram_arbiter #(
    .ADDR_WIDTH (23),
    .DATA_WIDTH (32),
    .MAX_PENDING(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_req     (wr_req),
    .wr_ack     (wr_ack),
    .rd_addr    (rd_addr),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .err        (err),
    .sdram_addr (sdram_addr),
    .sdram_data (sdram_data),
    .sdram_we   (sdram_we),
    .sdram_req  (sdram_req),
    .sdram_ack  (sdram_ack),
    .sdram_valid(sdram_valid),
    .sdram_q    (sdram_q)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr_req;
    logic [3:0]  rd_req;
    logic        ack;
    logic        valid;
    logic [31:0] q;
    logic        req;
    logic        we;
    logic [22:0] addr;
    logic [3:0]  rd_ack;
    logic [3:0]  rd_valid;
    logic        err;
    int          port;
    logic [31:0] pdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] rq, input logic ak, input logic vl,
                              input logic [31:0] q, input logic req, input logic [3:0] rak,
                              input logic [3:0] rvl, input logic er, input int port,
                              input logic [31:0] pdata);
    vec_t v;
    v.wr_req = 1'b0; v.rd_req = rq; v.ack = ak; v.valid = vl; v.q = q;
    v.req = req; v.we = 1'b0; v.addr = 23'h000123; v.rd_ack = rak; v.rd_valid = rvl;
    v.err = er; v.port = port; v.pdata = pdata;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pword(input int p);
    return rd_data[p*32 +: 32];
  endfunction

  function automatic logic [22:0] paddr(input int p);
    return rd_addr[p*23 +: 23];
  endfunction

  task automatic do_reset(input string nm);
    @(negedge clk);
    wr_req = 1'b0; rd_req = '0; sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;
    reset_n = 1'b0;
    #1;
    check({nm, " reset outputs"},
          {sdram_req, sdram_we, wr_ack, rd_ack, rd_valid, err, sdram_addr, sdram_data},
          '0);
    check({nm, " reset rd_data"}, rd_data, '0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  // Called just after a negedge; waits for a request, acks it, optionally returns data.
  task automatic serve(input string nm, input logic is_wr, input int port, input logic [31:0] q,
                       input logic give_valid, input logic [3:0] rd_after, input logic wr_after);
    int n = 0;
    logic [3:0] exp_ack;
    while (sdram_req !== 1'b1 && n < 20) begin
      @(negedge clk); #1; n++;
    end
    check({nm, " req seen"}, sdram_req, 1'b1);
    check({nm, " we"}, sdram_we, is_wr);
    check({nm, " addr"}, sdram_addr, is_wr ? wr_addr : paddr(port));
    check({nm, " data"}, sdram_data, is_wr ? wr_data : 32'h0);
    exp_ack = is_wr ? 4'b0000 : (4'b0001 << port);
    sdram_ack = 1'b1;
    #1;
    check({nm, " acks"}, {wr_ack, rd_ack}, {is_wr, exp_ack});
    @(negedge clk);
    sdram_ack = 1'b0; rd_req = rd_after; wr_req = wr_after;
    sdram_valid = give_valid; sdram_q = q;
    #1;
    check({nm, " req cleared"}, sdram_req, 1'b0);
    if (give_valid) begin
      @(negedge clk);
      sdram_valid = 1'b0;
      #1;
      check({nm, " rd_valid"}, rd_valid, 4'b0001 << port);
      check({nm, " rd_data"}, pword(port), q);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic stayed_low;
    int   exp_port;
    reset_n = 1'b0;
    wr_addr = 23'h7ABCDE;
    wr_data = 32'hCAFE0000;
    rd_addr = {23'h000103, 23'h000123, 23'h000101, 23'h000100};
    wr_req = 1'b0; rd_req = '0; sdram_ack = 1'b0; sdram_valid = 1'b0; sdram_q = '0;

    // Single read on port 2, then a stray return raising err.
    vecs.push_back(mk(4'b0100, 0, 0, 0,            0, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0100, 0, 0, 0,            1, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0100, 0, 0, 0,            1, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0100, 0, 0, 0,            1, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0100, 1, 0, 0,            1, 4'b0100, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 1, 32'hDEADBEEF, 0, 4'b0000, 4'b0000, 0, 2, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0100, 0, 2, 32'hDEADBEEF));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 0, 0, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 1, 32'h55,       0, 4'b0000, 4'b0000, 0, 3, 32'h0));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 1, 2, 32'hDEADBEEF));
    vecs.push_back(mk(4'b0000, 0, 0, 0,            0, 4'b0000, 4'b0000, 1, 1, 32'h0));

    do_reset("table");
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      wr_req = vecs[i].wr_req; rd_req = vecs[i].rd_req; sdram_ack = vecs[i].ack;
      sdram_valid = vecs[i].valid; sdram_q = vecs[i].q;
      #1;
      check($sformatf("row%0d ctl", i),
            {sdram_req, sdram_we, wr_ack, rd_ack, rd_valid, err},
            {vecs[i].req, vecs[i].we, 1'b0, vecs[i].rd_ack, vecs[i].rd_valid, vecs[i].err});
      check($sformatf("row%0d pdata", i), pword(vecs[i].port), vecs[i].pdata);
      if (vecs[i].req) check($sformatf("row%0d addr", i), sdram_addr, vecs[i].addr);
    end

    // Write beats simultaneous reads; held reads show the grant policy.
    do_reset("prio");
    wr_req = 1'b1; rd_req = 4'b1111;
    serve("prio wr", 1'b1, 0, 32'h0, 1'b0, 4'b1111, 1'b0);
    for (int k = 0; k < 4; k++) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
      exp_port = k;
`else
      exp_port = 0;
`endif
      serve($sformatf("prio rd%0d", k), 1'b0, exp_port, 32'hA0 + 32'(k), 1'b1,
            (k == 3) ? 4'b0000 : 4'b1111, 1'b0);
    end
    check("prio err", err, 1'b0);

    // Pending limit, in-order routing, coincident ack and valid.
    do_reset("pend");
    rd_req = 4'b1000;
    serve("pend p3", 1'b0, 3, 32'h0, 1'b0, 4'b0000, 1'b0);
    rd_req = 4'b0010;
    serve("pend p1", 1'b0, 1, 32'h0, 1'b0, 4'b0001, 1'b0);
    stayed_low = 1'b1;
    repeat (6) begin
      @(negedge clk); #1;
      if (sdram_req !== 1'b0) stayed_low = 1'b0;
    end
    check("pend third held", stayed_low, 1'b1);
    sdram_valid = 1'b1; sdram_q = 32'h11;
    @(negedge clk);
    sdram_valid = 1'b0;
    #1;
    check("pend first return", {rd_valid, pword(3)}, {4'b1000, 32'h11});
    check("pend req still low", sdram_req, 1'b0);
    @(negedge clk); #1;
    check("pend third req", {sdram_req, sdram_addr}, {1'b1, 23'h000100});
    sdram_ack = 1'b1; sdram_valid = 1'b1; sdram_q = 32'h22;
    #1;
    check("pend coincident ack", rd_ack, 4'b0001);
    @(negedge clk);
    sdram_ack = 1'b0; sdram_valid = 1'b0; rd_req = '0;
    #1;
    check("pend second return", {rd_valid, pword(1)}, {4'b0010, 32'h22});
    sdram_valid = 1'b1; sdram_q = 32'h33;
    @(negedge clk);
    sdram_valid = 1'b0;
    #1;
    check("pend third return", {rd_valid, pword(0), pword(3), err},
          {4'b0001, 32'h33, 32'h11, 1'b0});

    // Reset while busy drops everything; a later return is stray.
    do_reset("arst");
    rd_req = 4'b0100;
    serve("arst p2", 1'b0, 2, 32'h0, 1'b0, 4'b0001, 1'b0);
    @(negedge clk); #1;
    check("arst busy", sdram_req, 1'b1);
    sdram_ack = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("arst async drop", {sdram_req, sdram_we, wr_ack, rd_ack, rd_valid, err}, '0);
    @(negedge clk);
    sdram_ack = 1'b0; rd_req = '0; reset_n = 1'b1;
    #1;
    sdram_valid = 1'b1; sdram_q = 32'h99;
    @(negedge clk);
    sdram_valid = 1'b0;
    #1;
    check("arst stray", {err, rd_valid, pword(2)}, {1'b1, 4'b0000, 32'h0});
    rd_req = 4'b0001;
    @(negedge clk); #1;
    check("arst grant latency", {sdram_req, sdram_addr}, {1'b1, 23'h000100});
    sdram_ack = 1'b1;
    @(negedge clk);
    sdram_ack = 1'b0; rd_req = '0;
    #1;
    check("arst err sticky", err, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Shares the single SDRAM controller port (`sdram_addr/data/we/req/ack/valid/q`) between one write requester (ROM download path) and four read requesters (program, character, tile and sprite ROM fetchers) inside the game core. Grants one request at a time to the controller, tracks up to two reads in flight, and routes each returned read word back to the port that issued it. Sits between the game ROM fetch logic and the `sdram` controller instance, in the `clk` domain.

## Interface
Parameters:
- `ADDR_WIDTH`, 23, SDRAM word address width.
- `DATA_WIDTH`, 32, SDRAM data width.
- `MAX_PENDING`, 2, max reads accepted by controller but not yet returned (1..4).

Ports:
- `clk` in 1 system clock; only clock.
- `reset_n` in 1 asynchronous, active-low reset.
- `wr_addr` in ADDR_WIDTH write address (download path).
- `wr_data` in DATA_WIDTH write data.
- `wr_req` in 1 write request, level, held until `wr_ack`.
- `wr_ack` out 1 one-cycle pulse: write accepted by controller.
- `rd_addr` in 4*ADDR_WIDTH read addresses, port i at `[i*ADDR_WIDTH +: ADDR_WIDTH]`.
- `rd_req` in 4 read requests, level, held until matching `rd_ack` bit.
- `rd_ack` out 4 one-cycle pulse: read accepted by controller.
- `rd_valid` out 4 one-cycle pulse: `rd_data` of that port updated.
- `rd_data` out 4*DATA_WIDTH per-port read data, held until that port's next valid.
- `err` out 1 sticky: `sdram_valid` seen with no read pending.
- `sdram_addr` out ADDR_WIDTH, `sdram_data` out DATA_WIDTH, `sdram_we` out 1, `sdram_req` out 1 controller request.
- `sdram_ack` in 1, `sdram_valid` in 1, `sdram_q` in DATA_WIDTH controller responses.

## Operation
- Controller contract: `sdram_req` level until `sdram_ack` (one-cycle pulse); each accepted read yields exactly one `sdram_valid` pulse later, in acceptance order; writes yield no valid.
- States: IDLE, BUSY.
- IDLE: if `wr_req`, grant write. Else if any `rd_req` and pending count < MAX_PENDING, grant one read port (policy per Configuration). Grant registers owner, `sdram_addr`, `sdram_data` (write only, else 0), `sdram_we`, sets `sdram_req`; go BUSY. No request or pending full: stay IDLE.
- BUSY: hold `sdram_req` and outputs stable. On `sdram_ack`: `wr_ack` or `rd_ack[owner]` asserted combinationally in that cycle; at the edge `sdram_req` clears, state returns to IDLE; for reads, owner index pushed into tag FIFO.
- Write always has priority over reads; write grant does not require pending space.
- `sdram_valid`: pop tag FIFO head; `rd_data[tag]` <= `sdram_q`, `rd_valid[tag]` pulses next cycle. FIFO empty: set `err`, discard data.
- Push and pop in same cycle: both occur, count unchanged; pop uses pre-push head.
- Requester deasserting `rd_req` while granted but not acked: request still completes; data still returned.
- Reset values: `sdram_req`, `sdram_we`, `wr_ack`, `rd_ack`, `rd_valid`, `err` = 0; `sdram_addr`, `sdram_data`, `rd_data` = 0; state IDLE; FIFO empty; round-robin pointer = 3 (port 0 first).
- Reset mid-operation: all in-flight tracking dropped immediately; later stray `sdram_valid` sets `err`.

## Timing
- `rd_req`/`wr_req` sampled in IDLE -> `sdram_req` high next cycle (1-cycle grant latency).
- `sdram_ack` -> port ack same cycle (combinational); `sdram_req` low next cycle; earliest next grant evaluated the cycle after.
- Minimum spacing between controller requests: 2 cycles (IDLE + BUSY with immediate ack).
- `sdram_valid` -> `rd_valid`/`rd_data` next cycle (1-cycle return latency).
- A requester that drops `req` on the edge after its ack is never double-granted.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN` defined: read ports granted round-robin; search starts at (last granted read port + 1) mod 4; pointer updates only on read grant.
- Not defined: fixed priority, port 0 highest, port 3 lowest; no pointer state.

## Test plan
- Single read port 2, addr 0x000123, controller acks after 3 cycles, valid after 5 more with q=0xDEADBEEF -> `rd_ack[2]` one pulse, `rd_valid[2]` one pulse, `rd_data` port 2 = 0xDEADBEEF, others unchanged.
- `wr_req` and `rd_req`=4'b1111 asserted together -> write granted first (`sdram_we`=1, `sdram_data`=`wr_data`), reads follow; with round-robin order 0,1,2,3, without it port 0 repeatedly if held.
- Controller delays all valids: three reads requested -> only 2 acked; third `sdram_req` issued only after first valid.
- Valids return with q=0x11, 0x22 for reads from ports 3 then 1 -> port 3 gets 0x11, port 1 gets 0x22; `sdram_ack` and `sdram_valid` coincident -> count unchanged, correct routing.
- `sdram_valid` with nothing pending -> `err`=1 and stays 1 until reset; no `rd_valid`.
- `reset_n` low while BUSY -> `sdram_req`, acks, valids drop to 0 asynchronously; after release, first `rd_req[0]` produces `sdram_req` one cycle later.
